// File: rtl/rcv_drain_ctrl.sv
// Drains bytes from rcv_block into a small FIFO with a one-cycle data_read handshake.
// Define RCV_DRAIN_ERR_CNT_EN to build the framing/overrun error event counters.
module rcv_drain_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       data_ready,
    input  logic [7:0]                 rx_data,
    input  logic                       framing_error,
    input  logic                       overrun_error,
    output logic                       data_read,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    input  logic                       clr_cnt,
    output logic [7:0]                 frame_err_cnt,
    output logic [7:0]                 ovr_err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [7:0]         mem [DEPTH];
    logic               push;
    logic               pop;

    // Full check uses the pre-edge count, so a same-edge pop never admits a push while full.
    assign push      = (state == IDLE) && data_ready && (fifo_count < CNT_W'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign out_valid = (fifo_count != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            data_read <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        state     <= ACK;
                        data_read <= 1'b1;
                    end
                end
                ACK: begin
                    state     <= WAIT;
                    data_read <= 1'b0;
                end
                WAIT: begin
                    data_read <= 1'b0;
                    if (!data_ready) state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    data_read <= 1'b0;
                end
            endcase
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

`ifdef RCV_DRAIN_ERR_CNT_EN
    logic fe_d_p0;
    logic oe_d_p0;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fe_d_p0       <= 1'b0;
            oe_d_p0       <= 1'b0;
            frame_err_cnt <= 8'h00;
            ovr_err_cnt   <= 8'h00;
        end else begin
            fe_d_p0 <= framing_error;
            oe_d_p0 <= overrun_error;
            if (clr_cnt) begin
                frame_err_cnt <= 8'h00;
                ovr_err_cnt   <= 8'h00;
            end else begin
                if (framing_error && !fe_d_p0) frame_err_cnt <= sat_inc(frame_err_cnt);
                if (overrun_error && !oe_d_p0) ovr_err_cnt   <= sat_inc(ovr_err_cnt);
            end
        end
    end
`else
    logic unused_err_inputs;
    assign unused_err_inputs = &{1'b0, framing_error, overrun_error, clr_cnt};
    assign frame_err_cnt     = 8'h00;
    assign ovr_err_cnt       = 8'h00;
`endif

endmodule

// File: tb/tb_rcv_drain_ctrl.sv
// Directed self-checking bench for rcv_drain_ctrl (DEPTH=4); error-counter
// expectations follow whether RCV_DRAIN_ERR_CNT_EN is defined.
module tb_rcv_drain_ctrl;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       data_ready;
    logic [7:0] rx_data;
    logic       framing_error;
    logic       overrun_error;
    logic       data_read;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_count;
    logic       clr_cnt;
    logic [7:0] frame_err_cnt;
    logic [7:0] ovr_err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 tb_clk = ~tb_clk;

    rcv_drain_ctrl #(.DEPTH(4)) dut (
        .clk           (tb_clk),
        .n_rst         (n_rst),
        .data_ready    (data_ready),
        .rx_data       (rx_data),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .data_read     (data_read),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_count    (fifo_count),
        .clr_cnt       (clr_cnt),
        .frame_err_cnt (frame_err_cnt),
        .ovr_err_cnt   (ovr_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // Full handshake: capture edge, ACK->WAIT edge, WAIT->IDLE edge.
    task automatic send_byte(input logic [7:0] b);
        data_ready = 1'b1;
        rx_data    = b;
        step();
        chk("send_ack", data_read, 1'b1);
        data_ready = 1'b0;
        step();
        chk("send_ack_drop", data_read, 1'b0);
        step();
    endtask

    task automatic pop_byte(input logic [7:0] exp);
        chk("pop_valid", out_valid, 1'b1);
        chk("pop_head", out_data, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic pulse_fe();
        framing_error = 1'b1;
        step();
        framing_error = 1'b0;
        step();
    endtask

    initial begin
        n_rst = 1'b0; data_ready = 1'b0; rx_data = 8'h00;
        framing_error = 1'b0; overrun_error = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        #2;
        chk("rst_data_read", data_read, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_fcnt", frame_err_cnt, 8'd0);
        chk("rst_ocnt", ovr_err_cnt, 8'd0);
        step(); step();
        n_rst = 1'b1;
        step();

        // Single byte
        data_ready = 1'b1; rx_data = 8'hD5;
        step();
        chk("single_dr", data_read, 1'b1);
        chk("single_valid", out_valid, 1'b1);
        chk("single_data", out_data, 8'hD5);
        chk("single_count", fifo_count, 3'd1);
        data_ready = 1'b0;
        step();
        chk("single_dr_low", data_read, 1'b0);
        step();
        pop_byte(8'hD5);
        chk("single_empty", out_valid, 1'b0);

        // out_ready while empty is ignored
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("empty_pop_count", fifo_count, 3'd0);

        // Fill and ordered drain
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        chk("fill_count", fifo_count, 3'd4);
        for (int i = 1; i <= 4; i++) pop_byte(8'(i));
        chk("drain_count", fifo_count, 3'd0);
        chk("drain_valid", out_valid, 1'b0);

        // Full stall, then pop on the same edge as a pending push
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
        data_ready = 1'b1; rx_data = 8'h15;
        step();
        chk("full_dr", data_read, 1'b0);
        chk("full_count", fifo_count, 3'd4);
        step();
        chk("full_dr2", data_read, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("full_pop_no_push", data_read, 1'b0);
        chk("full_pop_count", fifo_count, 3'd3);
        step();
        chk("late_capture_dr", data_read, 1'b1);
        chk("late_capture_count", fifo_count, 3'd4);
        data_ready = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) pop_byte(8'h12 + 8'(i));
        chk("stall_drain_count", fifo_count, 3'd0);

        // Simultaneous push and pop at count 2
        send_byte(8'h21);
        send_byte(8'h22);
        chk("pp_pre_count", fifo_count, 3'd2);
        data_ready = 1'b1; rx_data = 8'h23; out_ready = 1'b1;
        step();
        out_ready = 1'b0; data_ready = 1'b0;
        chk("pp_count", fifo_count, 3'd2);
        chk("pp_dr", data_read, 1'b1);
        chk("pp_head", out_data, 8'h22);
        step(); step();
        pop_byte(8'h22);
        pop_byte(8'h23);
        chk("pp_empty", out_valid, 1'b0);

        // Error counters
        pulse_fe();
        framing_error = 1'b1;
        step(); step();
        framing_error = 1'b0;
        step();
        pulse_fe();
        overrun_error = 1'b1;
        step(); step();
        overrun_error = 1'b0;
        step();
`ifdef RCV_DRAIN_ERR_CNT_EN
        chk("fcnt_3", frame_err_cnt, 8'd3);
        chk("ocnt_1", ovr_err_cnt, 8'd1);
`else
        chk("fcnt_off", frame_err_cnt, 8'd0);
        chk("ocnt_off", ovr_err_cnt, 8'd0);
`endif
        clr_cnt = 1'b1; framing_error = 1'b1;
        step();
        clr_cnt = 1'b0; framing_error = 1'b0;
        step();
        chk("clr_fcnt", frame_err_cnt, 8'd0);
        chk("clr_ocnt", ovr_err_cnt, 8'd0);
        for (int i = 0; i < 300; i++) pulse_fe();
`ifdef RCV_DRAIN_ERR_CNT_EN
        chk("fcnt_sat", frame_err_cnt, 8'd255);
`else
        chk("fcnt_sat_off", frame_err_cnt, 8'd0);
`endif
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr2_fcnt", frame_err_cnt, 8'd0);

        // Reset while in WAIT with three bytes queued
        send_byte(8'h31);
        send_byte(8'h32);
        data_ready = 1'b1; rx_data = 8'h33;
        step();
        step();
        chk("wait_count", fifo_count, 3'd3);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_dr", data_read, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_count", fifo_count, 3'd0);
        data_ready = 1'b0;
        #2;
        n_rst = 1'b1;
        step();
        send_byte(8'h41);
        chk("post_rst_count", fifo_count, 3'd1);
        chk("post_rst_head", out_data, 8'h41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
